// File: rtl/gcttt_int_pkg.sv
// Shared definitions for the interrupt controller and the fetch stage.
package gcttt_int_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } int_state_e;

  localparam logic [3:0]  RtiOpcode   = 4'b0011;
  localparam logic [15:0] HandlerPc   = 16'h0005;
  localparam int unsigned DefaultNsrc = 4;

endpackage

// File: rtl/int_edge_det.sv
// Single-line rising-edge detector. The history register resets high so a line
// already asserted at reset release does not fire.
module int_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic irq_edge
);

  logic irq_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_q <= 1'b1;
    end else begin
      irq_prev_q <= irq;
    end
  end

  assign irq_edge = irq & ~irq_prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Multi-source interrupt controller: edge capture, pending/mask/overrun state,
// fixed-priority arbitration and a request/service handshake with fetch.
module int_ctrl
  import gcttt_int_pkg::*;
#(
  parameter int unsigned NSRC = DefaultNsrc,
  parameter int unsigned VW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_in,
  input  logic            ovr_clr,
  input  logic            int_ack,
  input  logic            rti,
  output logic            int_req,
  output logic [VW-1:0]   vector,
  output logic            in_service,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask_out,
  output logic [NSRC-1:0] overrun
);

  int_state_e      state_q;
  logic            int_req_q, in_service_q;
  logic [VW-1:0]   vector_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] overrun_q, overrun_d;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] irq_edge;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] ack_clr;

  for (genvar i = 0; i < NSRC; i++) begin : g_edge
    int_edge_det u_edge_det (
      .clk      (clk),
      .rst      (rst),
      .irq      (irq[i]),
      .irq_edge (irq_edge[i])
    );
  end

  // Lowest set index wins.
  function automatic logic [VW-1:0] prio_enc(input logic [NSRC-1:0] req);
    prio_enc = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) prio_enc = VW'(i);
    end
  endfunction

  assign eligible = pending_q & ~mask_q;

  always_comb begin
    ack_clr = '0;
    if (state_q == StReq && int_ack) ack_clr = NSRC'(1) << vector_q;
    // Set terms are OR-ed last so a coincident edge beats the clear.
    pending_d = (pending_q & ~ack_clr) | irq_edge;
    overrun_d = (ovr_clr ? '0 : overrun_q) | (irq_edge & pending_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      overrun_q <= '0;
      mask_q    <= '1;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (mask_wr) mask_q <= mask_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      vector_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|eligible) begin
            state_q   <= StReq;
            int_req_q <= 1'b1;
            vector_q  <= prio_enc(eligible);
          end
        end
        StReq: begin
          if (int_ack) begin
            state_q      <= StService;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b1;
          end
        end
        StService: begin
          if (rti) begin
            state_q      <= StIdle;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          int_req_q    <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign int_req    = int_req_q;
  assign in_service = in_service_q;
  assign vector     = vector_q;
  assign pending    = pending_q;
  assign mask_out   = mask_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: a per-cycle vector table plus hand sequences.
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq;
  logic       mask_wr;
  logic [3:0] mask_in;
  logic       ovr_clr;
  logic       int_ack;
  logic       rti;
  logic       int_req;
  logic [2:0] vector;
  logic       in_service;
  logic [3:0] pending;
  logic [3:0] mask_out;
  logic [3:0] overrun;

  int n_chk  = 0;
  int n_fail = 0;

  int_ctrl #(.NSRC(4), .VW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_wr    (mask_wr),
    .mask_in    (mask_in),
    .ovr_clr    (ovr_clr),
    .int_ack    (int_ack),
    .rti        (rti),
    .int_req    (int_req),
    .vector     (vector),
    .in_service (in_service),
    .pending    (pending),
    .mask_out   (mask_out),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irq;
    logic       mwr;
    logic [3:0] min;
    logic       oclr;
    logic       ack;
    logic       rti;
    logic       req;
    logic [2:0] vec;
    logic       insv;
    logic [3:0] pend;
    logic [3:0] ovr;
    logic [3:0] mask;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] i, input logic mw, input logic [3:0] mi,
                     input logic oc, input logic ak, input logic rt,
                     input logic rq, input logic [2:0] vc, input logic sv,
                     input logic [3:0] pd, input logic [3:0] ov, input logic [3:0] mk);
    vec_t v;
    v = '{i, mw, mi, oc, ak, rt, rq, vc, sv, pd, ov, mk};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int tag, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h, expected %0h", nm, tag, act, exp);
    end
  endtask

  task automatic check_all(input int tag, input logic rq, input logic [2:0] vc,
                           input logic sv, input logic [3:0] pd, input logic [3:0] ov,
                           input logic [3:0] mk);
    chk("int_req", tag, {7'b0, int_req}, {7'b0, rq});
    chk("vector", tag, {5'b0, vector}, {5'b0, vc});
    chk("in_service", tag, {7'b0, in_service}, {7'b0, sv});
    chk("pending", tag, {4'b0, pending}, {4'b0, pd});
    chk("overrun", tag, {4'b0, overrun}, {4'b0, ov});
    chk("mask", tag, {4'b0, mask_out}, {4'b0, mk});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic [3:0] i, input logic mw, input logic [3:0] mi,
                     input logic oc, input logic ak, input logic rt);
    irq = i; mask_wr = mw; mask_in = mi; ovr_clr = oc; int_ack = ak; rti = rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    irq = 4'b0001; mask_wr = 0; mask_in = 0; ovr_clr = 0; int_ack = 0; rti = 0;
    #1;
    check_all(900, 0, 0, 0, 4'h0, 4'h0, 4'hF);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // irq[0] held high through reset release: unmask, no pending must appear.
    add(4'b0001, 1, 4'h0, 0, 0, 0,  0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(4'b0000, 0, 4'h0, 0, 0, 0,  0, 0, 0, 4'h0, 4'h0, 4'h0);
    // Single source 2: pending, request, ack, rti.
    add(4'b0100, 0, 4'h0, 0, 0, 0,  0, 0, 0, 4'h4, 4'h0, 4'h0);
    add(4'b0000, 0, 4'h0, 0, 0, 0,  1, 2, 0, 4'h4, 4'h0, 4'h0);
    add(4'b0000, 0, 4'h0, 0, 0, 0,  1, 2, 0, 4'h4, 4'h0, 4'h0);
    add(4'b0000, 0, 4'h0, 0, 1, 0,  0, 2, 1, 4'h0, 4'h0, 4'h0);
    add(4'b0000, 0, 4'h0, 0, 0, 1,  0, 2, 0, 4'h0, 4'h0, 4'h0);
    add(4'b0000, 0, 4'h0, 0, 0, 0,  0, 2, 0, 4'h0, 4'h0, 4'h0);
    // Sources 3 and 1 together: 1 first, 3 one idle cycle after rti.
    add(4'b1010, 0, 4'h0, 0, 0, 0,  0, 2, 0, 4'hA, 4'h0, 4'h0);
    add(4'b1010, 0, 4'h0, 0, 0, 0,  1, 1, 0, 4'hA, 4'h0, 4'h0);
    add(4'b1010, 0, 4'h0, 0, 1, 0,  0, 1, 1, 4'h8, 4'h0, 4'h0);
    add(4'b1010, 0, 4'h0, 0, 0, 1,  0, 1, 0, 4'h8, 4'h0, 4'h0);
    add(4'b1010, 0, 4'h0, 0, 0, 0,  1, 3, 0, 4'h8, 4'h0, 4'h0);
    add(4'b1010, 0, 4'h0, 0, 1, 0,  0, 3, 1, 4'h0, 4'h0, 4'h0);
    add(4'b1010, 0, 4'h0, 0, 0, 1,  0, 3, 0, 4'h0, 4'h0, 4'h0);
    add(4'b0000, 0, 4'h0, 0, 0, 0,  0, 3, 0, 4'h0, 4'h0, 4'h0);
    // Vector frozen in REQ despite higher-priority edge and masking source 2.
    add(4'b0100, 0, 4'h0, 0, 0, 0,  0, 3, 0, 4'h4, 4'h0, 4'h0);
    add(4'b0100, 0, 4'h0, 0, 0, 0,  1, 2, 0, 4'h4, 4'h0, 4'h0);
    add(4'b0101, 1, 4'h4, 0, 0, 0,  1, 2, 0, 4'h5, 4'h0, 4'h4);
    add(4'b0101, 0, 4'h0, 0, 0, 0,  1, 2, 0, 4'h5, 4'h0, 4'h4);
    add(4'b0101, 0, 4'h0, 0, 1, 0,  0, 2, 1, 4'h1, 4'h0, 4'h4);
    add(4'b0101, 0, 4'h0, 0, 0, 1,  0, 2, 0, 4'h1, 4'h0, 4'h4);
    add(4'b0101, 0, 4'h0, 0, 0, 0,  1, 0, 0, 4'h1, 4'h0, 4'h4);
    add(4'b0101, 0, 4'h0, 0, 1, 0,  0, 0, 1, 4'h0, 4'h0, 4'h4);
    add(4'b0101, 1, 4'h0, 0, 0, 1,  0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(4'b0000, 0, 4'h0, 0, 0, 0,  0, 0, 0, 4'h0, 4'h0, 4'h0);

    foreach (tbl[k]) begin
      cyc(tbl[k].irq, tbl[k].mwr, tbl[k].min, tbl[k].oclr, tbl[k].ack, tbl[k].rti);
      check_all(k, tbl[k].req, tbl[k].vec, tbl[k].insv, tbl[k].pend, tbl[k].ovr, tbl[k].mask);
    end

    // Overrun: second edge while pending sets the flag, only one service.
    cyc(4'b0010, 0, 0, 0, 0, 0); check_all(100, 0, 0, 0, 4'h2, 4'h0, 4'h0);
    cyc(4'b0000, 0, 0, 0, 0, 0); check_all(101, 1, 1, 0, 4'h2, 4'h0, 4'h0);
    cyc(4'b0010, 0, 0, 0, 0, 0); check_all(102, 1, 1, 0, 4'h2, 4'h2, 4'h0);
    cyc(4'b0000, 0, 0, 0, 1, 0); check_all(103, 0, 1, 1, 4'h0, 4'h2, 4'h0);
    // int_ack in SERVICE is ignored.
    cyc(4'b0000, 0, 0, 0, 1, 0); check_all(104, 0, 1, 1, 4'h0, 4'h2, 4'h0);
    cyc(4'b0000, 0, 0, 0, 0, 1); check_all(105, 0, 1, 0, 4'h0, 4'h2, 4'h0);
    // rti in IDLE is ignored; no second service of source 1.
    cyc(4'b0000, 0, 0, 0, 0, 1); check_all(106, 0, 1, 0, 4'h0, 4'h2, 4'h0);
    cyc(4'b0000, 0, 0, 1, 0, 0); check_all(107, 0, 1, 0, 4'h0, 4'h0, 4'h0);
    // Overrun edge coinciding with ovr_clr keeps the flag.
    cyc(4'b0010, 0, 0, 0, 0, 0); check_all(108, 0, 1, 0, 4'h2, 4'h0, 4'h0);
    cyc(4'b0000, 0, 0, 0, 0, 0); check_all(109, 1, 1, 0, 4'h2, 4'h0, 4'h0);
    cyc(4'b0010, 0, 0, 1, 0, 0); check_all(110, 1, 1, 0, 4'h2, 4'h2, 4'h0);
    cyc(4'b0000, 0, 0, 1, 1, 0); check_all(111, 0, 1, 1, 4'h0, 4'h0, 4'h0);
    cyc(4'b0000, 0, 0, 0, 0, 1); check_all(112, 0, 1, 0, 4'h0, 4'h0, 4'h0);

    // Set on the acknowledge edge for the same source wins over the clear.
    cyc(4'b0001, 0, 0, 0, 0, 0); check_all(120, 0, 1, 0, 4'h1, 4'h0, 4'h0);
    cyc(4'b0000, 0, 0, 0, 0, 0); check_all(121, 1, 0, 0, 4'h1, 4'h0, 4'h0);
    cyc(4'b0001, 0, 0, 0, 1, 0); check_all(122, 0, 0, 1, 4'h1, 4'h1, 4'h0);
    cyc(4'b0000, 0, 0, 0, 0, 1); check_all(123, 0, 0, 0, 4'h1, 4'h1, 4'h0);
    cyc(4'b0000, 0, 0, 0, 0, 0); check_all(124, 1, 0, 0, 4'h1, 4'h1, 4'h0);
    cyc(4'b0100, 0, 0, 0, 1, 0); check_all(125, 0, 0, 1, 4'h4, 4'h1, 4'h0);

    // Asynchronous reset while in SERVICE clears everything before the next edge.
    rst = 1'b1;
    #1;
    check_all(130, 0, 0, 0, 4'h0, 4'h0, 4'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(4'b0000, 1, 4'h0, 0, 0, 0); check_all(131, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    cyc(4'b0000, 0, 4'h0, 0, 0, 0); check_all(132, 0, 0, 0, 4'h0, 4'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
